// File: rtl/exe_stage_pkg.sv
// Shared constants and types for the execute stage: operand widths, ALU
// opcodes, shift types, forwarding selects and the multiplier FSM states.
package exe_stage_pkg;

    localparam int ADDRESS_LEN         = 32;
    localparam int REGISTER_LEN        = 32;
    localparam int EXECUTE_COMMAND_LEN = 4;
    localparam int SHIFT_OPERAND_LEN   = 12;
    localparam int SIGNED_IMM_LEN      = 24;
    localparam int MUL_COUNT_LEN       = 5;

    // ALU opcodes; memory and compare/test instructions reuse ADD/SUB/AND
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_MOV = 4'b0001;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_MVN = 4'b1001;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_ADD = 4'b0010;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_ADC = 4'b0011;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_SUB = 4'b0100;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_SBC = 4'b0101;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_AND = 4'b0110;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_ORR = 4'b0111;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_EOR = 4'b1000;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_MUL = 4'b1010;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_LDR = EXE_ADD;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_STR = EXE_ADD;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_CMP = EXE_SUB;
    localparam logic [EXECUTE_COMMAND_LEN-1:0] EXE_TST = EXE_AND;

    // Forwarding selects; 2'b11 falls back to the register file
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b01;
    localparam logic [1:0] FWD_WB      = 2'b10;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_type_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

    // 32-bit rotate right; a zero amount returns the value unchanged
    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative 32x32 shift-add multiplier (low 32 bits of the product).
// Protocol: start is level-sensitive and sampled only in IDLE. busy is high
// combinationally in the IDLE cycle that sees start and for all 32 BUSY
// cycles; done is high for exactly one cycle (DONE) while product is final.
// The requester must hold its operands stable while busy is high and must
// drop start during the DONE cycle, otherwise a new multiply is launched.
module mul_iter
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [1:0]  state_dbg
);

    mul_state_e               state_q;
    mul_state_e               state_d;
    logic [MUL_COUNT_LEN-1:0] count_q;
    logic [31:0]              acc_q;
    logic [31:0]              mcand_q;
    logic [31:0]              mplier_q;

    // State register; reset returns to IDLE immediately, even mid-multiply
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MUL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                if (start && !rst) begin
                    busy    = 1'b1;
                    state_d = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                busy = !rst;
                if (count_q == 5'd31) begin
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: begin
                done    = 1'b1;
                state_d = MUL_IDLE;
            end
            default: begin
                state_d = MUL_IDLE;
            end
        endcase
    end

    // Datapath: latch operands on launch, then one shift-add step per BUSY cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (start) begin
                        count_q  <= '0;
                        acc_q    <= '0;
                        mcand_q  <= a;
                        mplier_q <= b;
                    end
                end
                MUL_BUSY: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 5'd1;
                end
                default: begin
                    acc_q <= acc_q;
                end
            endcase
        end
    end

    assign product   = acc_q;
    assign state_dbg = state_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, second-operand (val2) generation,
// single-cycle ALU with NZCV flags, branch target adder and a multi-cycle
// MUL that stalls the pipeline through exe_busy.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDRESS_LEN-1:0]         pc_in,
    input  logic [EXECUTE_COMMAND_LEN-1:0] execute_command_in,
    input  logic                           mem_read_in,
    input  logic                           mem_write_in,
    input  logic                           wb_enable_in,
    input  logic                           branch_taken_in,
    input  logic                           status_write_enable_in,
    input  logic                           immediate_in,
    input  logic [REGISTER_LEN-1:0]        val_rn_in,
    input  logic [REGISTER_LEN-1:0]        val_rm_in,
    input  logic [SHIFT_OPERAND_LEN-1:0]   shift_operand_in,
    input  logic [SIGNED_IMM_LEN-1:0]      signed_immediate_in,
    input  logic [3:0]                     status_register_in,
    input  logic [1:0]                     sel_src1,
    input  logic [1:0]                     sel_src2,
    input  logic [REGISTER_LEN-1:0]        mem_fwd_value,
    input  logic [REGISTER_LEN-1:0]        wb_fwd_value,
    output logic [REGISTER_LEN-1:0]        alu_result,
    output logic [REGISTER_LEN-1:0]        store_value,
    output logic [ADDRESS_LEN-1:0]         branch_address,
    output logic [3:0]                     status_bits,
    output logic                           mem_read_out,
    output logic                           mem_write_out,
    output logic                           wb_enable_out,
    output logic                           exe_busy,
    output logic [1:0]                     mul_state_dbg
);

    logic [31:0] op1;
    logic [31:0] rm_fwd;
    logic [31:0] val2;
    logic [31:0] alu_value;
    logic [31:0] mul_product;
    logic [32:0] add_sum;
    logic [4:0]  shift_amt;
    shift_type_e shift_type;
    logic        carry_in;
    logic        flag_c;
    logic        flag_v;
    logic [3:0]  alu_nzcv;
    logic        mul_start;
    logic        mul_busy;
    logic        mul_done;
    logic        unused_branch_taken;

    // The taken bit is resolved earlier in the pipe and is not needed here
    assign unused_branch_taken = branch_taken_in;

    // Forwarding muxes pick the freshest copy of Rn and Rm
    always_comb begin
        case (sel_src1)
            FWD_MEM: op1 = mem_fwd_value;
            FWD_WB:  op1 = wb_fwd_value;
            default: op1 = val_rn_in;
        endcase
        case (sel_src2)
            FWD_MEM: rm_fwd = mem_fwd_value;
            FWD_WB:  rm_fwd = wb_fwd_value;
            default: rm_fwd = val_rm_in;
        endcase
    end

    // val2: rotated imm8, memory offset, or shifted Rm
    always_comb begin
        shift_amt  = shift_operand_in[11:7];
        shift_type = shift_type_e'(shift_operand_in[6:5]);
        val2       = rm_fwd;
        if (immediate_in) begin
            val2 = ror32({24'd0, shift_operand_in[7:0]}, {shift_operand_in[11:8], 1'b0});
        end else if (mem_read_in || mem_write_in) begin
            val2 = {20'd0, shift_operand_in};
        end else begin
            case (shift_type)
                SHIFT_LSL: val2 = rm_fwd << shift_amt;
                SHIFT_LSR: val2 = rm_fwd >> shift_amt;
                SHIFT_ASR: val2 = $unsigned($signed(rm_fwd) >>> shift_amt);
                SHIFT_ROR: val2 = ror32(rm_fwd, shift_amt);
                default:   val2 = rm_fwd;
            endcase
        end
    end

    // ALU and flags; C and V pass through unless an arithmetic op produces them
    always_comb begin
        carry_in  = status_register_in[1];
        add_sum   = '0;
        alu_value = '0;
        flag_c    = status_register_in[1];
        flag_v    = status_register_in[0];
        case (execute_command_in)
            EXE_MOV: alu_value = val2;
            EXE_MVN: alu_value = ~val2;
            EXE_ADD, EXE_ADC: begin
                add_sum   = {1'b0, op1} + {1'b0, val2}
                          + {32'd0, (execute_command_in == EXE_ADC) && carry_in};
                alu_value = add_sum[31:0];
                flag_c    = add_sum[32];
                flag_v    = (op1[31] == val2[31]) && (add_sum[31] != op1[31]);
            end
            EXE_SUB, EXE_SBC: begin
                // Subtract as op1 + ~val2 + carry; C is the ARM "no borrow" bit
                add_sum   = {1'b0, op1} + {1'b0, ~val2}
                          + {32'd0, (execute_command_in == EXE_SBC) ? carry_in : 1'b1};
                alu_value = add_sum[31:0];
                flag_c    = add_sum[32];
                flag_v    = (op1[31] != val2[31]) && (add_sum[31] != op1[31]);
            end
            EXE_AND: alu_value = op1 & val2;
            EXE_ORR: alu_value = op1 | val2;
            EXE_EOR: alu_value = op1 ^ val2;
            EXE_MUL: alu_value = mul_done ? mul_product : 32'd0;
            default: alu_value = '0;
        endcase
        alu_nzcv = {alu_value[31], (alu_value == 32'd0), flag_c, flag_v};
    end

    assign mul_start = (execute_command_in == EXE_MUL);

    mul_iter u_mul_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (mul_start),
        .a         (op1),
        .b         (rm_fwd),
        .busy      (mul_busy),
        .done      (mul_done),
        .product   (mul_product),
        .state_dbg (mul_state_dbg)
    );

    assign exe_busy       = mul_busy;
    assign alu_result     = alu_value;
    assign store_value    = rm_fwd;
    assign branch_address = pc_in + {{6{signed_immediate_in[23]}}, signed_immediate_in, 2'b00};
    // A stalled MUL must not leak memory or writeback side effects downstream
    assign mem_read_out   = mem_read_in  && !mul_busy;
    assign mem_write_out  = mem_write_in && !mul_busy;
    assign wb_enable_out  = wb_enable_in && !mul_busy;
    assign status_bits    = (status_write_enable_in && !mul_busy) ? alu_nzcv : status_register_in;

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed corner cases, a randomized ALU
// sweep against an arithmetic reference model, and multi-cycle MUL runs.
module tb_exe_stage;
    import exe_stage_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] pc_in;
    logic [3:0]  execute_command_in;
    logic        mem_read_in, mem_write_in, wb_enable_in, branch_taken_in;
    logic        status_write_enable_in, immediate_in;
    logic [31:0] val_rn_in, val_rm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_immediate_in;
    logic [3:0]  status_register_in;
    logic [1:0]  sel_src1, sel_src2;
    logic [31:0] mem_fwd_value, wb_fwd_value;
    logic [31:0] alu_result, store_value, branch_address;
    logic [3:0]  status_bits;
    logic        mem_read_out, mem_write_out, wb_enable_out, exe_busy;
    logic [1:0]  mul_state_dbg;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    exe_stage dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .execute_command_in(execute_command_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .wb_enable_in(wb_enable_in),
        .branch_taken_in(branch_taken_in), .status_write_enable_in(status_write_enable_in),
        .immediate_in(immediate_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .shift_operand_in(shift_operand_in), .signed_immediate_in(signed_immediate_in),
        .status_register_in(status_register_in), .sel_src1(sel_src1), .sel_src2(sel_src2),
        .mem_fwd_value(mem_fwd_value), .wb_fwd_value(wb_fwd_value),
        .alu_result(alu_result), .store_value(store_value), .branch_address(branch_address),
        .status_bits(status_bits), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .wb_enable_out(wb_enable_out), .exe_busy(exe_busy), .mul_state_dbg(mul_state_dbg)
    );

    // ---------------- scoreboard primitives ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_val2(input logic imm, input logic mem,
                                             input logic [11:0] so, input logic [31:0] rm);
        logic [63:0] dbl;
        int          amt;
        if (imm) begin
            dbl = {24'd0, so[7:0], 24'd0, so[7:0]} >> (2 * int'(so[11:8]));
            return dbl[31:0];
        end
        if (mem) return {20'd0, so};
        amt = int'(so[11:7]);
        case (so[6:5])
            2'd0: return rm << amt;
            2'd1: return rm >> amt;
            2'd2: return $unsigned($signed(rm) >>> amt);
            default: begin
                dbl = {rm, rm} >> amt;
                return dbl[31:0];
            end
        endcase
    endfunction

    function automatic logic ovf(input longint v);
        return (v > 64'sd2147483647) || (v < -64'sd2147483648);
    endfunction

    function automatic void ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                    input logic [31:0] b, input logic [3:0] fin,
                                    output logic [31:0] r, output logic [3:0] f);
        longint ua, ub, sa, sb, s, extra;
        logic   c, v;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c  = fin[1];
        v  = fin[0];
        r  = 32'd0;
        case (cmd)
            EXE_MOV: r = b;
            EXE_MVN: r = ~b;
            EXE_AND: r = a & b;
            EXE_ORR: r = a | b;
            EXE_EOR: r = a ^ b;
            EXE_ADD, EXE_ADC: begin
                extra = (cmd == EXE_ADC) ? longint'(fin[1]) : 0;
                s = ua + ub + extra;
                r = 32'(s);
                c = (s >= 64'sh1_0000_0000);
                v = ovf(sa + sb + extra);
            end
            EXE_SUB, EXE_SBC: begin
                extra = (cmd == EXE_SBC) ? 1 - longint'(fin[1]) : 0;
                r = 32'(ua - ub - extra);
                c = (ua >= ub + extra);
                v = ovf(sa - sb - extra);
            end
            default: r = 32'd0;
        endcase
        f = {r[31], (r == 32'd0), c, v};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_zero();
        pc_in = '0; execute_command_in = '0; mem_read_in = 0; mem_write_in = 0;
        wb_enable_in = 0; branch_taken_in = 0; status_write_enable_in = 0; immediate_in = 0;
        val_rn_in = '0; val_rm_in = '0; shift_operand_in = '0; signed_immediate_in = '0;
        status_register_in = '0; sel_src1 = '0; sel_src2 = '0; mem_fwd_value = '0; wb_fwd_value = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".alu"}, alu_result, 32'd0);
        chk({tag, ".store"}, store_value, 32'd0);
        chk({tag, ".branch"}, branch_address, 32'd0);
        chk({tag, ".nzcv"}, {28'd0, status_bits}, 32'd0);
        chk({tag, ".ctl"}, {28'd0, mem_read_out, mem_write_out, wb_enable_out, exe_busy}, 32'd0);
        chk({tag, ".state"}, {30'd0, mul_state_dbg}, {30'd0, MUL_IDLE});
    endtask

    // Compare every combinational output against the model for the current inputs
    task automatic check_comb(input string tag);
        logic [31:0] a, rm, v2, r, br;
        logic [3:0]  f;
        a  = (sel_src1 == 2'd1) ? mem_fwd_value : (sel_src1 == 2'd2) ? wb_fwd_value : val_rn_in;
        rm = (sel_src2 == 2'd1) ? mem_fwd_value : (sel_src2 == 2'd2) ? wb_fwd_value : val_rm_in;
        v2 = ref_val2(immediate_in, mem_read_in | mem_write_in, shift_operand_in, rm);
        ref_alu(execute_command_in, a, v2, status_register_in, r, f);
        br = pc_in + 32'(int'($signed(signed_immediate_in)) * 4);
        chk({tag, ".alu"}, alu_result, r);
        chk({tag, ".nzcv"}, {28'd0, status_bits},
            {28'd0, status_write_enable_in ? f : status_register_in});
        chk({tag, ".store"}, store_value, rm);
        chk({tag, ".branch"}, branch_address, br);
        chk({tag, ".ctl"}, {28'd0, mem_read_out, mem_write_out, wb_enable_out, exe_busy},
            {28'd0, mem_read_in, mem_write_in, wb_enable_in, 1'b0});
    endtask

    task automatic mul_setup(input logic [31:0] a, input logic [31:0] b);
        execute_command_in = EXE_MUL; val_rn_in = a; val_rm_in = b;
        sel_src1 = 2'd0; sel_src2 = 2'd0; immediate_in = 0; shift_operand_in = '0;
        mem_read_in = 1; mem_write_in = 1; wb_enable_in = 1; status_write_enable_in = 1;
        status_register_in = 4'($urandom_range(0, 15));
    endtask

    // Wait out a launched multiply; inputs were driven at a falling edge
    task automatic mul_wait(input string tag);
        logic [63:0] full;
        logic [31:0] p;
        int          busy_cycles;
        bit          done_seen;
        full = {32'd0, val_rn_in} * {32'd0, val_rm_in};
        exp_q.push_back(full[31:0]);
        busy_cycles = 0;
        done_seen   = 0;
        for (int cyc = 0; cyc < 100 && !done_seen; cyc++) begin
            #1;
            if (exe_busy) begin
                busy_cycles++;
                chk({tag, ".bubble"}, {29'd0, mem_read_out, mem_write_out, wb_enable_out}, 32'd0);
                chk({tag, ".hold_nzcv"}, {28'd0, status_bits}, {28'd0, status_register_in});
                @(negedge clk);
            end else begin
                done_seen = 1;
                p = exp_q.pop_front();
                chk({tag, ".busy_cycles"}, 32'(busy_cycles), 32'd33);
                chk({tag, ".product"}, alu_result, p);
                chk({tag, ".done_ctl"}, {29'd0, mem_read_out, mem_write_out, wb_enable_out}, 32'd7);
                chk({tag, ".nzcv"}, {28'd0, status_bits},
                    {28'd0, p[31], (p == 32'd0), status_register_in[1:0]});
                chk({tag, ".state"}, {30'd0, mul_state_dbg}, {30'd0, MUL_DONE});
            end
        end
        chk({tag, ".completed"}, 32'(done_seen), 32'd1);
        // Next instruction enters: the pipe moves on after the DONE cycle
        execute_command_in = EXE_ADD; mem_read_in = 0; mem_write_in = 0;
        @(negedge clk);
        #1;
        chk({tag, ".back_idle"}, {30'd0, mul_state_dbg}, {30'd0, MUL_IDLE});
        check_comb({tag, ".after"});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] ops [9];
        logic [31:0] ra, rb;
        ops = '{EXE_MOV, EXE_MVN, EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC, EXE_AND, EXE_ORR, EXE_EOR};

        drive_zero();
        rst = 1'b1;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("post_reset");

        // Signed overflow on ADD with immediate
        @(negedge clk);
        drive_zero();
        execute_command_in = EXE_ADD; val_rn_in = 32'h7FFF_FFFF; immediate_in = 1;
        shift_operand_in = 12'h001; status_write_enable_in = 1;
        #1;
        chk("add_ovf.res", alu_result, 32'h8000_0000);
        chk("add_ovf.flags", {28'd0, status_bits}, 32'b1001);
        check_comb("add_ovf");

        // CMP equal operands
        @(negedge clk);
        drive_zero();
        execute_command_in = EXE_CMP; val_rn_in = 32'd5; val_rm_in = 32'd5; status_write_enable_in = 1;
        #1;
        chk("cmp_eq.res", alu_result, 32'd0);
        chk("cmp_eq.flags", {28'd0, status_bits}, 32'b0110);

        // Rotated immediate and arithmetic shift right
        @(negedge clk);
        drive_zero();
        execute_command_in = EXE_MOV; immediate_in = 1; shift_operand_in = {4'd4, 8'hFF};
        #1;
        chk("mov_rot.res", alu_result, 32'hFF00_0000);
        @(negedge clk);
        drive_zero();
        execute_command_in = EXE_MOV; val_rm_in = 32'h8000_0000; shift_operand_in = 12'h240;
        #1;
        chk("mov_asr.res", alu_result, 32'hF800_0000);

        // Forwarded Rn plus negative branch offset
        @(negedge clk);
        drive_zero();
        execute_command_in = EXE_ADD; sel_src1 = 2'b01; mem_fwd_value = 32'd9; val_rn_in = 32'h55;
        immediate_in = 1; shift_operand_in = 12'h001;
        signed_immediate_in = 24'hFF_FFFF; pc_in = 32'h100;
        #1;
        chk("fwd_mem.res", alu_result, 32'd10);
        chk("branch_neg", branch_address, 32'h0000_00FC);

        // Randomized ALU sweep
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            execute_command_in = ops[$urandom_range(0, 8)];
            val_rn_in = $urandom; val_rm_in = $urandom;
            mem_fwd_value = $urandom; wb_fwd_value = $urandom;
            sel_src1 = 2'($urandom_range(0, 3)); sel_src2 = 2'($urandom_range(0, 3));
            immediate_in = 1'($urandom_range(0, 1));
            mem_read_in = ($urandom_range(0, 3) == 0); mem_write_in = ($urandom_range(0, 3) == 0);
            wb_enable_in = 1'($urandom_range(0, 1)); branch_taken_in = 1'($urandom_range(0, 1));
            status_write_enable_in = 1'($urandom_range(0, 1));
            shift_operand_in = 12'($urandom_range(0, 4095));
            signed_immediate_in = 24'($urandom_range(0, 24'hFF_FFFF));
            status_register_in = 4'($urandom_range(0, 15)); pc_in = $urandom;
            #1;
            check_comb($sformatf("rand%0d", i));
        end

        // Multiplies
        @(negedge clk);
        mul_setup(32'h0001_0000, 32'h0001_0001);
        mul_wait("mul_big");
        for (int i = 0; i < 3; i++) begin
            ra = $urandom; rb = $urandom;
            @(negedge clk);
            mul_setup(ra, rb);
            mul_wait($sformatf("mul_rand%0d", i));
        end

        // Reset in the middle of a multiply, then a fresh one
        @(negedge clk);
        ra = $urandom; rb = $urandom;
        mul_setup(ra, rb);
        repeat (11) @(negedge clk);
        #1;
        chk("mid.busy_before", {31'd0, exe_busy}, 32'd1);
        chk("mid.state_before", {30'd0, mul_state_dbg}, {30'd0, MUL_BUSY});
        rst = 1'b1;
        #1;
        chk("mid.busy_rst", {31'd0, exe_busy}, 32'd0);
        chk("mid.state_rst", {30'd0, mul_state_dbg}, {30'd0, MUL_IDLE});
        chk("mid.ctl_rst", {29'd0, mem_read_out, mem_write_out, wb_enable_out}, 32'd7);
        mul_setup(32'd3, 32'd7);
        #1;
        chk("mid.busy_hold", {31'd0, exe_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mul_wait("mul_3x7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
